alu_arbiter: RTL and testbench

- Shares the single 32-bit integer ALU between two requesters: port 0 is the execute stage and port 1 is the branch/address unit.
- Each requester presents operands and a 4-bit ALU opcode with a valid/ready handshake.
- The block arbitrates between them, drives the shared ALU combinationally and registers the result into one output slot.
- The output slot is tagged with the winning requester's id and uses a valid/ready handshake with backpressure.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_arbiter_if.sv | 56 +++++
 rtl/alu.sv | 41 ++++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU and its two-port arbiter:
//                ALU opcodes ({funct7[5], funct3}), requester ids and widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Requester ids carried on the result tag
    localparam logic REQ_EX = 1'b0;   // execute stage
    localparam logic REQ_BR = 1'b1;   // branch/address unit

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Bundle of the two request channels, the result channel and
//                the grant counters of alu_arbiter.
//                master : requesters / result consumer side
//                slave  : arbiter side
//  Ports       : req0_*/req1_* (valid, ready, a, b, op), res_* (valid, ready,
//                data, id), grant_cnt0/grant_cnt1
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
    import alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [3:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [3:0]        req1_op;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_id;

    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  res_valid, res_data, res_id,
        output res_ready,
        input  grant_cnt0, grant_cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output res_valid, res_data, res_id,
        input  res_ready,
        output grant_cnt0, grant_cnt1
    );

endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational 32-bit integer ALU.
//  Ports       : a, b (in, 32)  operands
//                op   (in, 4)   opcode {funct7[5], funct3}
//                y    (out, 32) result; unknown opcodes return 0
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    input  wire logic [3:0]        op,
    output logic      [DATA_W-1:0] y
);

    logic [4:0] w_shamt;

    assign w_shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << w_shamt;
            ALU_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> w_shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> w_shamt);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one ALU between the execute stage (port 0) and the
//                branch/address unit (port 1). Arbitrates, muxes the winner
//                onto the ALU and registers the result into a single output
//                slot tagged with the winner's id. One-cycle latency, one
//                result per cycle when the consumer keeps res_ready high.
//  Parameters  : PRIO_MODE 0 = round-robin, 1 = fixed priority (port 0 wins)
//  Ports       : clk, rst (async, active-high)
//                bus (alu_arbiter_if.slave): request/result channels and
//                saturating grant counters
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int PRIO_MODE = 0
)
(
    input  wire logic     clk,
    input  wire logic     rst,
    alu_arbiter_if.slave  bus
);

    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_id;
    logic              r_rr;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_slot_free;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_sel_id;
    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [3:0]        w_alu_op;
    logic [DATA_W-1:0] w_alu_y;

    // The slot may drain and refill in the same cycle.
    assign w_slot_free = !r_res_valid || bus.res_ready;

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        // Nothing is accepted while reset is held, even though the slot
        // looks empty then.
        if (w_slot_free && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (PRIO_MODE == 1 || r_rr == REQ_EX) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else if (bus.req0_valid) begin
                w_grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_sel_id = w_grant1 ? REQ_BR : REQ_EX;
    assign w_alu_a  = w_grant1 ? bus.req1_a  : bus.req0_a;
    assign w_alu_b  = w_grant1 ? bus.req1_b  : bus.req0_b;
    assign w_alu_op = w_grant1 ? bus.req1_op : bus.req0_op;

    alu u_alu (
        .a  (w_alu_a),
        .b  (w_alu_b),
        .op (w_alu_op),
        .y  (w_alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= REQ_EX;
            r_rr        <= REQ_EX;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else if (w_grant0 || w_grant1) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_alu_y;
            r_res_id    <= w_sel_id;
            // Prefer the port that just lost on the next contention.
            r_rr        <= ~w_sel_id;
            if (w_grant0 && r_cnt0 != {CNT_W{1'b1}}) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_grant1 && r_cnt1 != {CNT_W{1'b1}}) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end else if (bus.res_ready) begin
            // Drain with no refill; res_data keeps its last value.
            r_res_valid <= 1'b0;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_id     = r_res_id;
    assign bus.grant_cnt0 = r_cnt0;
    assign bus.grant_cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter (round-robin build).
//                A behavioural model tracks the expected slot contents and
//                counters; directed vectors add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests = 0;
    int fails = 0;

    alu_arbiter_if bus ();

    alu_arbiter #(.PRIO_MODE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference ALU, phrased arithmetically
    // ------------------------------------------------------------------
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int unsigned sh;
        logic [31:0] fill;
        sh = b[4:0];
        case (op)
            4'b0000: return a + b;
            4'b1000: return a + ~b + 32'd1;
            4'b0001: return a << sh;
            4'b0010: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: begin
                fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (a >> sh) | fill;
            end
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model of the slot, preference and counters
    // ------------------------------------------------------------------
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_id    = 1'b0;
    int          m_pref  = 0;      // port preferred on contention
    int          m_cnt[2] = '{0, 0};

    // Which port should be accepted now (-1 for none), from the model state
    function automatic int winner();
        if (rst) return -1;
        if (m_valid && !bus.res_ready) return -1;
        if (bus.req0_valid && bus.req1_valid) return m_pref;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int w;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 1'b0;
            m_pref  = 0;
            m_cnt   = '{0, 0};
        end else begin
            w = winner();
            if (w == 0) begin
                m_data = alu_ref(bus.req0_a, bus.req0_b, bus.req0_op);
            end else if (w == 1) begin
                m_data = alu_ref(bus.req1_a, bus.req1_b, bus.req1_op);
            end
            if (w >= 0) begin
                m_valid  = 1'b1;
                m_id     = (w == 1);
                m_pref   = 1 - w;
                if (m_cnt[w] < 65535) m_cnt[w] = m_cnt[w] + 1;
            end else if (m_valid && bus.res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Every-cycle compare, mid-cycle
    always @(negedge clk) begin
        int w;
        if (!rst) begin
            w = winner();
            chk("res_valid",  {31'd0, bus.res_valid},  {31'd0, m_valid});
            chk("res_data",   bus.res_data,            m_data);
            if (m_valid) chk("res_id", {31'd0, bus.res_id}, {31'd0, m_id});
            chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, (w == 0)});
            chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, (w == 1)});
            chk("grant_cnt0", {16'd0, bus.grant_cnt0}, m_cnt[0]);
            chk("grant_cnt1", {16'd0, bus.grant_cnt1}, m_cnt[1]);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    endtask

    logic [31:0] cont_data[4] = '{32'd2, 32'hF800_0000, 32'd2, 32'hF800_0000};

    initial begin
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        bus.res_ready = 1'b0;

        // Reset: a request presented during reset must not be accepted
        step(); step();
        set0(1'b1, 32'd1, 32'd1, 4'b0000);
        #1;
        chk("ready_in_reset", {31'd0, bus.req0_ready}, 32'd0);
        set0(1'b0, '0, '0, '0);
        step();
        rst = 1'b0;
        step();
        chk("idle_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("idle_data",  bus.res_data, 32'd0);
        chk("idle_cnt0",  {16'd0, bus.grant_cnt0}, 32'd0);
        chk("idle_cnt1",  {16'd0, bus.grant_cnt1}, 32'd0);

        // Single SUB on port 0
        bus.res_ready = 1'b1;
        set0(1'b1, 32'd7, 32'd5, 4'b1000);
        #1;
        chk("single_ready", {31'd0, bus.req0_ready}, 32'd1);
        step();
        set0(1'b0, '0, '0, '0);
        chk("single_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("single_data",  bus.res_data, 32'd2);
        chk("single_id",    {31'd0, bus.res_id}, 32'd0);
        chk("single_cnt0",  {16'd0, bus.grant_cnt0}, 32'd1);

        // Compares and illegal opcode on port 1 (also hands preference back to port 0)
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
        step();
        chk("slt_data", bus.res_data, 32'd1);
        chk("slt_id",   {31'd0, bus.res_id}, 32'd1);
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0011);
        step();
        chk("sltu_data", bus.res_data, 32'd0);
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1111);
        step();
        chk("illegal_data", bus.res_data, 32'd0);
        set1(1'b0, '0, '0, '0);
        step();
        chk("drain_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("drain_hold",  bus.res_data, 32'd0);

        // Round-robin contention
        set0(1'b1, 32'd1, 32'd1, 4'b0000);
        set1(1'b1, 32'h8000_0000, 32'd4, 4'b1101);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cont_data", bus.res_data, cont_data[i]);
            chk("cont_id",   {31'd0, bus.res_id}, i % 2);
        end
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        chk("cont_cnt0", {16'd0, bus.grant_cnt0}, 32'd3);
        chk("cont_cnt1", {16'd0, bus.grant_cnt1}, 32'd5);

        // Backpressure: port 1 waits while the slot is stalled
        set0(1'b1, 32'd10, 32'd20, 4'b0000);
        step();
        set0(1'b0, '0, '0, '0);
        bus.res_ready = 1'b0;
        set1(1'b1, 32'd3, 32'd4, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'd0, bus.req1_ready}, 32'd0);
            chk("bp_data",  bus.res_data, 32'd30);
            step();
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.req1_ready}, 32'd1);
        step();
        set1(1'b0, '0, '0, '0);
        chk("bp_next_data", bus.res_data, 32'd7);
        chk("bp_next_id",   {31'd0, bus.res_id}, 32'd1);
        chk("bp_cnt1",      {16'd0, bus.grant_cnt1}, 32'd6);

        // Asynchronous reset during a stall
        set0(1'b1, 32'd100, 32'd1, 4'b1000);
        step();
        set0(1'b0, '0, '0, '0);
        bus.res_ready = 1'b0;
        step();
        chk("stall_data", bus.res_data, 32'd99);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("arst_data",  bus.res_data, 32'd0);
        chk("arst_cnt0",  {16'd0, bus.grant_cnt0}, 32'd0);
        chk("arst_cnt1",  {16'd0, bus.grant_cnt1}, 32'd0);
        step();
        rst = 1'b0;
        bus.res_ready = 1'b1;
        set0(1'b1, 32'd1, 32'd1, 4'b0000);
        set1(1'b1, 32'h8000_0000, 32'd4, 4'b1101);
        step();
        chk("post_rst_id",   {31'd0, bus.res_id}, 32'd0);
        chk("post_rst_data", bus.res_data, 32'd2);
        step();
        chk("post_rst_id2",  {31'd0, bus.res_id}, 32'd1);
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
